// File: rtl/ram_loader_if.sv
// Bundle of the loader control, byte stream, CPU and RAM port signals.
// slave is the ram_loader's view of the bundle; master is its environment's view.
interface ram_loader_if;
    logic        load_start;
    logic [15:0] load_len;
    logic        load_abort;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load_busy;
    logic        load_done;
    logic        cpu_stall;
    logic        cpu_wen;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        ram_wen;
    logic [15:0] ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    modport slave (
        input  load_start, load_len, load_abort, byte_valid, byte_data,
               cpu_wen, cpu_addr, cpu_din, ram_dout,
        output byte_ready, load_busy, load_done, cpu_stall, cpu_dout,
               ram_wen, ram_addr, ram_din
    );

    modport master (
        output load_start, load_len, load_abort, byte_valid, byte_data,
               cpu_wen, cpu_addr, cpu_din, ram_dout,
        input  byte_ready, load_busy, load_done, cpu_stall, cpu_dout,
               ram_wen, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_loader.sv
// RAM port front-end: muxes the 16-bit RAM between the CPU and a byte-stream
// loader that packs big-endian byte pairs into consecutive words.
module ram_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    ram_loader_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [7:0]  lo_byte_q, lo_byte_d;

    logic        accept;
    logic        busy;
    logic [15:0] cnt_inc;
    logic [15:0] load_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= 16'd0;
            len_q      <= 16'd0;
            hi_byte_q  <= 8'd0;
            lo_byte_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            hi_byte_q  <= hi_byte_d;
            lo_byte_q  <= lo_byte_d;
        end
    end

    assign cnt_inc   = word_cnt_q + 16'd1;
    assign load_addr = BASE_ADDR + word_cnt_q;
    assign accept    = bus.byte_valid && bus.byte_ready;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        hi_byte_d  = hi_byte_q;
        lo_byte_d  = lo_byte_q;
        unique case (state_q)
            IDLE: begin
                // Abort outranks start when both arrive together.
                if (bus.load_start && !bus.load_abort) begin
                    len_d      = bus.load_len;
                    word_cnt_d = 16'd0;
                    state_d    = (bus.load_len != 16'd0) ? HI : DONE;
                end
            end
            HI: begin
                if (bus.load_abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    hi_byte_d = bus.byte_data;
                    state_d   = LO;
                end
            end
            LO: begin
                if (bus.load_abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    lo_byte_d = bus.byte_data;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                word_cnt_d = cnt_inc;
                if (bus.load_abort)
                    state_d = IDLE;
                else if (cnt_inc == len_q)
                    state_d = DONE;
                else
                    state_d = HI;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q == HI) || (state_q == LO) || (state_q == WRITE);
    assign bus.byte_ready = (state_q == HI) || (state_q == LO);
    assign bus.load_busy  = busy;
    assign bus.cpu_stall  = busy;
    assign bus.load_done  = (state_q == DONE);
    assign bus.cpu_dout   = bus.ram_dout;

    // CPU writes issued while the loader owns the port are dropped.
    always_comb begin
        if (busy) begin
            bus.ram_wen  = (state_q == WRITE) && !rst;
            bus.ram_addr = load_addr;
            bus.ram_din  = {hi_byte_q, lo_byte_q};
        end else begin
            bus.ram_wen  = bus.cpu_wen && !rst;
            bus.ram_addr = bus.cpu_addr;
            bus.ram_din  = bus.cpu_din;
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (base 0x0000 and 0xFFFF) share one stimulus
// and each drives its own RAM model; write logs are checked against a word-list model.
module tb_ram_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_loader_if if0();
    ram_loader_if if1();

    ram_loader #(.BASE_ADDR(16'h0000)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    ram_loader #(.BASE_ADDR(16'hFFFF)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    assign if1.load_start = if0.load_start;
    assign if1.load_len   = if0.load_len;
    assign if1.load_abort = if0.load_abort;
    assign if1.byte_valid = if0.byte_valid;
    assign if1.byte_data  = if0.byte_data;
    assign if1.cpu_wen    = if0.cpu_wen;
    assign if1.cpu_addr   = if0.cpu_addr;
    assign if1.cpu_din    = if0.cpu_din;

    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];
    assign if0.ram_dout = mem0[if0.ram_addr];
    assign if1.ram_dout = mem1[if1.ram_addr];

    logic [31:0] wlog0[$];
    logic [31:0] wlog1[$];
    logic [7:0]  tx[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0, last_wr_cyc = -100, done_cyc = -1, done_cnt = 0, ready_bad = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (if0.ram_wen) begin
                mem0[if0.ram_addr] <= if0.ram_din;
                wlog0.push_back({if0.ram_addr, if0.ram_din});
            end
            if (if1.ram_wen) begin
                mem1[if1.ram_addr] <= if1.ram_din;
                wlog1.push_back({if1.ram_addr, if1.ram_din});
            end
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (if0.ram_wen && if0.load_busy) last_wr_cyc <= cyc;
        if (if0.ram_wen && if0.load_busy && if0.byte_ready) ready_bad <= ready_bad + 1;
        if (if0.load_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wlog0.delete();
        wlog1.delete();
        done_cnt = 0;
    endtask

    // Model: word i = {tx[2i], tx[2i+1]} lands at (base + i) mod 65536.
    task automatic check_load(input int nw);
        logic [31:0] e;
        chk("wr_count0", wlog0.size(), nw);
        chk("wr_count1", wlog1.size(), nw);
        for (int i = 0; i < nw; i++) begin
            if (i < wlog0.size()) begin
                e = {16'((0 + i) % 65536), tx[2*i], tx[2*i+1]};
                chk("wr_base0", wlog0[i], e);
            end
            if (i < wlog1.size()) begin
                e = {16'((65535 + i) % 65536), tx[2*i], tx[2*i+1]};
                chk("wr_baseFFFF", wlog1[i], e);
            end
        end
    endtask

    // gap: 0 = always valid, 1 = valid every other cycle, 2 = random.
    task automatic run_load(input logic [15:0] len, input int gap, input int abort_after);
        int idx = 0;
        int budget = 0;
        bit v, acc;
        clear_logs();
        @(posedge clk); #1;
        if0.load_start = 1'b1;
        if0.load_len   = len;
        @(posedge clk); #1;
        if0.load_start = 1'b0;
        while (idx < tx.size() && budget < 2000) begin
            if (abort_after >= 0 && idx == abort_after) break;
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (budget % 2 == 1) : 1'($urandom_range(0, 1));
            if0.byte_valid = v;
            if0.byte_data  = tx[idx];
            @(negedge clk);
            acc = v && if0.byte_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        if0.byte_valid = 1'b0;
        if (abort_after >= 0) begin
            if0.load_abort = 1'b1;
            @(posedge clk); #1;
            if0.load_abort = 1'b0;
            @(negedge clk);
            chk("abort_busy", if0.load_busy, 1'b0);
            chk("abort_cpu_port", if0.ram_addr, if0.cpu_addr);
        end
        while (if0.load_busy && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("load_in_budget", budget < 2000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if0.load_start = 0; if0.load_len = 0; if0.load_abort = 0;
        if0.byte_valid = 0; if0.byte_data = 0;
        if0.cpu_wen = 1'b1; if0.cpu_addr = 16'h0010; if0.cpu_din = 16'h1111;

        // Reset with cpu_wen high
        @(negedge clk);
        chk("rst_ram_wen0", if0.ram_wen, 1'b0);
        chk("rst_ram_wen1", if1.ram_wen, 1'b0);
        chk("rst_busy", if0.load_busy, 1'b0);
        chk("rst_ready", if0.byte_ready, 1'b0);
        chk("rst_done", if0.load_done, 1'b0);
        if0.cpu_wen = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", if0.load_busy, 1'b0);
        chk("idle_stall", if0.cpu_stall, 1'b0);
        chk("idle_ram_wen", if0.ram_wen, 1'b0);

        // Two-word load, no gaps
        tx = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(16'd2, 0, -1);
        check_load(2);
        chk("done_once", done_cnt, 1);
        chk("done_after_write", done_cyc, last_wr_cyc + 1);

        // Same load with gaps
        run_load(16'd2, 1, -1);
        check_load(2);
        chk("done_once_gap", done_cnt, 1);
        chk("no_accept_in_write", ready_bad, 0);

        // Zero-length load
        clear_logs();
        @(posedge clk); #1;
        if0.load_start = 1'b1; if0.load_len = 16'd0;
        @(negedge clk);
        chk("len0_done_c1", if0.load_done, 1'b0);
        @(posedge clk); #1;
        if0.load_start = 1'b0;
        @(negedge clk);
        chk("len0_done_c2", if0.load_done, 1'b1);
        chk("len0_busy", if0.load_busy, 1'b0);
        @(negedge clk);
        chk("len0_done_c3", if0.load_done, 1'b0);
        chk("len0_no_writes", wlog0.size(), 0);

        // Abort after the 3rd byte
        if0.cpu_addr = 16'h0042;
        run_load(16'd2, 0, 3);
        check_load(1);
        chk("abort_no_done", done_cnt, 0);

        // Start and abort together: no load
        clear_logs();
        @(posedge clk); #1;
        if0.load_start = 1'b1; if0.load_abort = 1'b1; if0.load_len = 16'd2;
        @(posedge clk); #1;
        if0.load_start = 1'b0; if0.load_abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", if0.load_busy, 1'b0);
        chk("start_abort_done", if0.load_done, 1'b0);

        // Reset in the middle of a load
        @(posedge clk); #1;
        if0.load_start = 1'b1; if0.load_len = 16'd3;
        if0.byte_valid = 1'b1; if0.byte_data = 8'hAA;
        @(posedge clk); #1;
        if0.load_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", if0.load_busy, 1'b0);
        chk("midrst_ready", if0.byte_ready, 1'b0);
        if0.byte_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", if0.load_busy, 1'b0);

        // Randomized loads
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 5);
            tx.delete();
            for (int k = 0; k < 2 * n; k++) tx.push_back(8'($urandom_range(0, 255)));
            run_load(16'(n), 2, -1);
            check_load(n);
            chk("rand_done", done_cnt, 1);
        end
        chk("rand_no_accept_in_write", ready_bad, 0);

        // CPU write and readback in IDLE
        @(posedge clk); #1;
        if0.cpu_wen = 1'b1; if0.cpu_addr = 16'h0010; if0.cpu_din = 16'hBEEF;
        @(posedge clk); #1;
        if0.cpu_wen = 1'b0;
        @(negedge clk);
        chk("cpu_rd0", if0.cpu_dout, 16'hBEEF);
        chk("cpu_rd1", if1.cpu_dout, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
